// File: rtl/gt_link_ctrl.sv
// Per-lane GT bring-up and supervision controller.
// Sequences the lane resets, waits for TX reset-done and stable RX byte
// alignment, watches a running link for alignment loss and re-runs bring-up
// up to a bounded number of retries before parking in FAIL.
//
// Handshake note: this block has no valid/ready interface. i_link_en is a
// level request (1 = hold the link up); the GT status inputs are plain levels
// sampled through 2-flop synchronisers.
module gt_link_ctrl #(
  parameter int P_RST_CYCLES    = 10,
  parameter int P_TX_TIMEOUT    = 65535,
  parameter int P_ALIGN_TIMEOUT = 65535,
  parameter int P_STABLE_CYCLES = 16,
  parameter int P_LOSS_CYCLES   = 16,
  parameter int P_MAX_RETRY     = 8,
  parameter int P_CNT_W         = 17
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_link_en,
  input  logic       i_gt_tx_done,
  input  logic       i_gt_bytealign,
  output logic       o_gt_tx_rst,
  output logic       o_gt_rx_rst,
  output logic       o_link_up,
  output logic       o_link_fail,
  output logic [7:0] o_retry_cnt,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RST        = 3'd1,
    S_WAIT_TX    = 3'd2,
    S_WAIT_ALIGN = 3'd3,
    S_UP         = 3'd4,
    S_RETRY      = 3'd5,
    S_FAIL       = 3'd6
  } state_t;

  // Terminal counter values: each compare fires on the last cycle of a window.
  localparam logic [P_CNT_W-1:0] RST_LAST    = P_CNT_W'(P_RST_CYCLES - 1);
  localparam logic [P_CNT_W-1:0] TX_LAST     = P_CNT_W'(P_TX_TIMEOUT - 1);
  localparam logic [P_CNT_W-1:0] ALIGN_LAST  = P_CNT_W'(P_ALIGN_TIMEOUT - 1);
  localparam logic [P_CNT_W-1:0] STABLE_LAST = P_CNT_W'(P_STABLE_CYCLES - 1);
  localparam logic [P_CNT_W-1:0] LOSS_LAST   = P_CNT_W'(P_LOSS_CYCLES - 1);
  localparam logic [7:0]         MAX_RETRY   = 8'(P_MAX_RETRY);

  state_t             state_q, state_d;
  logic [P_CNT_W-1:0] cnt_q, cnt_d;
  logic [P_CNT_W-1:0] tmo_q, tmo_d;
  logic [7:0]         retry_q, retry_d;
  logic               tx_meta_q, tx_s_q, al_meta_q, al_s_q;
  logic               gt_rst_q, gt_rst_d;
  logic               up_q, up_d;
  logic               fail_q, fail_d;

  // Two-flop synchronisers for the asynchronous GT status flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_meta_q <= 1'b0;
      tx_s_q    <= 1'b0;
      al_meta_q <= 1'b0;
      al_s_q    <= 1'b0;
    end else begin
      tx_meta_q <= i_gt_tx_done;
      tx_s_q    <= tx_meta_q;
      al_meta_q <= i_gt_bytealign;
      al_s_q    <= al_meta_q;
    end
  end

  // State, counters and registered status outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      tmo_q    <= '0;
      retry_q  <= 8'd0;
      gt_rst_q <= 1'b1;
      up_q     <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      retry_q  <= retry_d;
      gt_rst_q <= gt_rst_d;
      up_q     <= up_d;
      fail_q   <= fail_d;
    end
  end

  // Next-state, counter updates and output decode of the next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    tmo_d   = '0;
    retry_d = retry_q;
    case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        retry_d = 8'd0;
        if (i_link_en) state_d = S_RST;
      end
      S_RST: begin
        if (cnt_q == RST_LAST) state_d = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (tx_s_q)                state_d = S_WAIT_ALIGN;
        else if (cnt_q == TX_LAST) state_d = S_RETRY;
      end
      S_WAIT_ALIGN: begin
        // cnt_q tracks the current run of aligned cycles, tmo_q time in state.
        cnt_d = al_s_q ? cnt_q + 1'b1 : '0;
        tmo_d = tmo_q + 1'b1;
        if (al_s_q && (cnt_q == STABLE_LAST)) state_d = S_UP;
        else if (tmo_q == ALIGN_LAST)         state_d = S_RETRY;
      end
      S_UP: begin
        // cnt_q tracks the current run of misaligned cycles.
        cnt_d = al_s_q ? '0 : cnt_q + 1'b1;
        if (!tx_s_q)                                state_d = S_RETRY;
        else if (!al_s_q && (cnt_q == LOSS_LAST))   state_d = S_RETRY;
      end
      S_RETRY: begin
        if (retry_q == MAX_RETRY) begin
          state_d = S_FAIL;
        end else begin
          retry_d = retry_q + 8'd1;
          state_d = S_RST;
        end
      end
      S_FAIL: begin
        cnt_d = '0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Dropping the enable overrides every other transition.
    if (!i_link_en) begin
      state_d = S_IDLE;
      retry_d = 8'd0;
    end

    if (state_d != state_q) begin
      cnt_d = '0;
      tmo_d = '0;
    end

    gt_rst_d = (state_d == S_IDLE) || (state_d == S_RST) ||
               (state_d == S_RETRY) || (state_d == S_FAIL);
    up_d     = (state_d == S_UP);
    fail_d   = (state_d == S_FAIL);
  end

  assign o_gt_tx_rst = gt_rst_q;
  assign o_gt_rx_rst = gt_rst_q;
  assign o_link_up   = up_q;
  assign o_link_fail = fail_q;
  assign o_retry_cnt = retry_q;
  assign o_state     = state_q;

endmodule
